// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned FifoDataWidth = 32;
  localparam int unsigned FifoDepth     = 8;
  localparam int unsigned FifoAeLevel   = 2;
  localparam int unsigned FifoAfLevel   = 6;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the synchronous FIFO: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, level flags, sticky error flags and optional
// first-word-fall-through read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FifoDataWidth,
  parameter int unsigned DEPTH      = FifoDepth,
  parameter int unsigned PTR_WIDTH  = 3,
  parameter int unsigned AE_LEVEL   = FifoAeLevel,
  parameter int unsigned AF_LEVEL   = FifoAfLevel,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrt,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  half_full,
  output logic                  almost_empty,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  if (PTR_WIDTH != clog2(DEPTH) || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of 2 >= 4 and PTR_WIDTH == log2(DEPTH)");
  end
  if (AE_LEVEL == 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL >= DEPTH) begin : g_bad_levels
    $error("sync_fifo_flags: require 0 < AE_LEVEL < AF_LEVEL < DEPTH");
  end

  localparam int unsigned CntWidth = PTR_WIDTH + 1;
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(DEPTH);
  localparam logic [CntWidth-1:0] CntHalf = CntWidth'(DEPTH / 2);
  localparam logic [CntWidth-1:0] CntAf   = CntWidth'(AF_LEVEL);
  localparam logic [CntWidth-1:0] CntAe   = CntWidth'(AE_LEVEL);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [PTR_WIDTH-1:0] PtrOne = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags are pure decodes of the count register.
  always_comb begin
    full         = (count_q == CntFull);
    almost_full  = (count_q >= CntAf);
    half_full    = (count_q >= CntHalf);
    almost_empty = (count_q <= CntAe);
    empty        = (count_q == '0);
  end

  assign wr_acc = wrt & ~full;
  assign rd_acc = read & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // A rejected request in the same cycle as clr_err keeps the error set.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wrt && full)  overflow_d  = 1'b1;
    if (read && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    assign data_out = mem_rdata;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_out_q <= '0;
      end else if (rd_acc) begin
        data_out_q <= mem_rdata;
      end
    end

    assign data_out = data_out_q;
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
